pl_ex_wb: RTL and testbench
===========================

# pl_ex_wb

Execute/write-back pipeline stage of the 8-bit RISC RNS processor. It accepts one decoded instruction per cycle from the IF/ID stage, after forwarding, and performs the lane-wise ALU operation or data-memory access. It resolves branches and produces the two write-side interfaces the front end consumes:
- register-file write-back (`wr_addr`, `wr_data`, `wr_en`);
- PC redirect (`branch_taken_EX`, `nxt_prog_ctr_EX`).

## Interface
Parameters:
- PROG_CTR_WID, 10, program counter width
- NUM_DOMAINS, 1, number of 8-bit RNS lanes; data width is NUM_DOMAINS*8

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-high reset
- id_valid  in  1  instruction on id_* is real; 0 = bubble
- id_opcode  in  4  opcode, encoding from the shared package
- id_dest  in  3  destination register address
- id_op1_data  in  NUM_DOMAINS*8  forwarded operand 1
- id_op2_data  in  NUM_DOMAINS*8  forwarded operand 2
- id_imm  in  8  immediate
- id_br_target  in  PROG_CTR_WID  branch/jump target
- dmem_rd_data  in  NUM_DOMAINS*8  data memory read data, valid 1 cycle after dmem_addr
- dmem_addr  out  8  data memory address
- dmem_wr_en  out  1  data memory write strobe
- dmem_wr_data  out  NUM_DOMAINS*8  store data
- branch_taken_EX  out  1  redirect the PC this cycle
- nxt_prog_ctr_EX  out  PROG_CTR_WID  redirect target
- destination_reg_addr  out  3  EX-stage destination, for forwarding
- reg_wr_en_reg  out  1  EX-stage instruction writes a register, for forwarding
- load_true_EX  out  1  EX-stage instruction is LD, for forwarding/hazard
- wr_addr  out  3  write-back register address
- wr_data  out  NUM_DOMAINS*8  write-back data
- wr_en  out  1  write-back enable

## Operation
Opcodes:
- 0 NOP
- 1 ADD, 2 SUB, 3 AND, 4 OR, 5 XOR
- 6 MOV (result = op1)
- 7 LDI (imm replicated into every lane)
- 8 LD, 9 ST
- A BZ, B BNZ, C BC, D JMP
- E–F treated as NOP

Stages:
- EX register: captures id_* at each edge. valid_ex = id_valid & ~squash.
- WB register: captures EX result at the next edge.

ALU:
- Lane-wise, each lane 8-bit modulo 256.
- carry = OR of lane carry-outs (ADD) or lane borrows (SUB).
- zero = entire NUM_DOMAINS*8 result equals 0.

Flags:
- Z and C registers update only when a valid ADD–XOR, MOV or LDI leaves EX.
- LD, ST, branches and NOP do not touch the flags.

Branches:
- branch_taken_EX = valid_ex & (JMP | BZ&Z | BNZ&~Z | BC&C).
- nxt_prog_ctr_EX = EX target.
- Taken branch sets squash, so the instruction captured at the following edge is invalidated (one-bubble penalty).

Memory:
- dmem_addr = op1 lane 0 + imm, mod 256.
- ST: dmem_wr_en = valid_ex & ST; dmem_wr_data = op2.
- LD: dmem_rd_data selected as wr_data during WB.

Write-back:
- wr_en = valid_wb & opcode ∈ {1–8}.
- wr_addr and wr_data come from the WB register.

Forwarding outputs:
- destination_reg_addr, reg_wr_en_reg and load_true_EX decode from the EX register.

## Timing
- Instruction sampled at edge k:
  - branch_taken_EX, dmem_* and forwarding outputs valid after edge k;
  - flags update at edge k+1;
  - wr_* valid after edge k+1.
- Register write latency is 2 edges from sampling. LD data arrives during the WB cycle.
- All registers (EX, WB, Z, C, squash) clear asynchronously on reset. Every output is 0 while reset is high and until the first valid instruction.
- Reset mid-operation:
  - a pending store's dmem_wr_en drops immediately;
  - a pending write-back is discarded.
- Branch directly behind a flag-setting op sees the updated flag, since both update at the same edge.
- Taken branch whose squashed successor is also a branch: the successor has no effect.
- Bubble (id_valid=0): no write, no store, no branch, flags held.
- Write to the same register on consecutive cycles: each retires in order; the last value wins.

## Structure
- Shared package holds:
  - opcode localparams;
  - the writes-register opcode set;
  - the lane ALU function (add/sub with carry per 8-bit lane).
- One natural sub-module: `rns_lane_alu`, one 8-bit lane, instantiated NUM_DOMAINS times by generate. It outputs result and carry.

## Test plan
- ADD: op1=0xF0, op2=0x20, dest=3 → after edge k+1: wr_en=1, wr_addr=3, wr_data=0x10; C=1, Z=0.
- SUB: op1=op2=0x55, then BZ target=0x1A0 next cycle → branch_taken_EX=1, nxt_prog_ctr_EX=0x1A0. The following instruction (ADD dest=2) produces no wr_en.
- ST op1=0x10, imm=0x05, op2=0x77 → dmem_wr_en=1, dmem_addr=0x15, dmem_wr_data=0x77, wr_en=0. Then LD op1=0x15, imm=0, dest=4, memory returns 0x77 → wr_data=0x77, wr_addr=4, load_true_EX=1 during EX.
- id_valid=0 for 3 cycles between ops → no wr_en, no dmem_wr_en, Z/C unchanged.
- Assert reset while an ST is in EX and an ADD is in WB → dmem_wr_en and wr_en drop the same cycle; all outputs 0 until the next valid instruction.
- NUM_DOMAINS=2, LDI imm=0x80 then ADD with itself → wr_data=0x0000; Z=1, C=1.

Source files
------------

// File: rtl/pl_ex_wb_pkg.sv
// pl_ex_wb_pkg
//   Shared definitions for the execute/write-back stage of the 8-bit RNS
//   processor: opcode encodings, opcode-class helpers and the per-lane
//   add/sub primitive.
package pl_ex_wb_pkg;

    localparam logic [3:0] OP_NOP = 4'h0;
    localparam logic [3:0] OP_ADD = 4'h1;
    localparam logic [3:0] OP_SUB = 4'h2;
    localparam logic [3:0] OP_AND = 4'h3;
    localparam logic [3:0] OP_OR  = 4'h4;
    localparam logic [3:0] OP_XOR = 4'h5;
    localparam logic [3:0] OP_MOV = 4'h6;
    localparam logic [3:0] OP_LDI = 4'h7;
    localparam logic [3:0] OP_LD  = 4'h8;
    localparam logic [3:0] OP_ST  = 4'h9;
    localparam logic [3:0] OP_BZ  = 4'hA;
    localparam logic [3:0] OP_BNZ = 4'hB;
    localparam logic [3:0] OP_BC  = 4'hC;
    localparam logic [3:0] OP_JMP = 4'hD;

    // ADD..LD write the register file.
    function automatic logic writes_reg(input logic [3:0] op);
        return (op >= OP_ADD) && (op <= OP_LD);
    endfunction

    // ADD..LDI update the Z/C flags.
    function automatic logic sets_flags(input logic [3:0] op);
        return (op >= OP_ADD) && (op <= OP_LDI);
    endfunction

    // One 8-bit lane; bit 8 is the carry-out (add) or borrow (sub).
    function automatic logic [8:0] lane_addsub(input logic [7:0] a,
                                               input logic [7:0] b,
                                               input logic       sub);
        logic [8:0] r;
        if (sub) r = {1'b0, a} - {1'b0, b};
        else     r = {1'b0, a} + {1'b0, b};
        return r;
    endfunction

endpackage

// File: rtl/pl_ex_wb_if.sv
// pl_ex_wb_if
//   Data-memory bus of the execute stage.
//   addr    : byte address
//   wr_en   : write strobe
//   wr_data : store data
//   rd_data : read data, one cycle after addr
//   master = execute stage side, slave = memory side.
interface pl_ex_wb_if #(
    parameter int unsigned DW = 8
);
    logic [7:0]    addr;
    logic          wr_en;
    logic [DW-1:0] wr_data;
    logic [DW-1:0] rd_data;

    modport master (output addr, output wr_en, output wr_data, input rd_data);
    modport slave  (input addr, input wr_en, input wr_data, output rd_data);
endinterface

// File: rtl/pl_ex_wb_rns_lane_alu.sv
// rns_lane_alu
//   One 8-bit RNS lane of the execute ALU.
//   op_i     : opcode
//   a_i, b_i : lane operands
//   imm_i    : immediate (LDI result)
//   result_o : lane result, mod 256
//   carry_o  : carry-out (ADD) or borrow (SUB), else 0
module rns_lane_alu
    import pl_ex_wb_pkg::*;
(
    input  logic [3:0] op_i,
    input  logic [7:0] a_i,
    input  logic [7:0] b_i,
    input  logic [7:0] imm_i,
    output logic [7:0] result_o,
    output logic       carry_o
);

    logic [8:0] sum;

    always_comb begin
        sum      = lane_addsub(a_i, b_i, op_i == OP_SUB);
        result_o = '0;
        carry_o  = 1'b0;
        case (op_i)
            OP_ADD, OP_SUB: begin
                result_o = sum[7:0];
                carry_o  = sum[8];
            end
            OP_AND:  result_o = a_i & b_i;
            OP_OR:   result_o = a_i | b_i;
            OP_XOR:  result_o = a_i ^ b_i;
            OP_MOV:  result_o = a_i;
            OP_LDI:  result_o = imm_i;
            default: result_o = '0;
        endcase
    end

endmodule

// File: rtl/pl_ex_wb.sv
// pl_ex_wb
//   Execute / write-back stage. EX register captures the decoded instruction,
//   WB register captures the EX result one edge later.
//   clk, reset (async, active-high)
//   id_*                 : decoded, forwarded instruction from IF/ID
//   dmem_*               : data-memory bus (read data one cycle after addr)
//   branch_taken_EX, nxt_prog_ctr_EX : PC redirect
//   destination_reg_addr, reg_wr_en_reg, load_true_EX : EX info for forwarding
//   wr_addr, wr_data, wr_en : register-file write-back
module pl_ex_wb
    import pl_ex_wb_pkg::*;
#(
    parameter int unsigned PROG_CTR_WID = 10,
    parameter int unsigned NUM_DOMAINS  = 1
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      id_valid,
    input  logic [3:0]                id_opcode,
    input  logic [2:0]                id_dest,
    input  logic [NUM_DOMAINS*8-1:0]  id_op1_data,
    input  logic [NUM_DOMAINS*8-1:0]  id_op2_data,
    input  logic [7:0]                id_imm,
    input  logic [PROG_CTR_WID-1:0]   id_br_target,
    input  logic [NUM_DOMAINS*8-1:0]  dmem_rd_data,
    output logic [7:0]                dmem_addr,
    output logic                      dmem_wr_en,
    output logic [NUM_DOMAINS*8-1:0]  dmem_wr_data,
    output logic                      branch_taken_EX,
    output logic [PROG_CTR_WID-1:0]   nxt_prog_ctr_EX,
    output logic [2:0]                destination_reg_addr,
    output logic                      reg_wr_en_reg,
    output logic                      load_true_EX,
    output logic [2:0]                wr_addr,
    output logic [NUM_DOMAINS*8-1:0]  wr_data,
    output logic                      wr_en
);

    localparam int unsigned DW = NUM_DOMAINS * 8;

    logic                    ex_valid_q, ex_valid_d;
    logic [3:0]              ex_op_q,    ex_op_d;
    logic [2:0]              ex_dest_q,  ex_dest_d;
    logic [DW-1:0]           ex_op1_q,   ex_op1_d;
    logic [DW-1:0]           ex_op2_q,   ex_op2_d;
    logic [7:0]              ex_imm_q,   ex_imm_d;
    logic [PROG_CTR_WID-1:0] ex_tgt_q,   ex_tgt_d;

    logic                    wb_valid_q, wb_valid_d;
    logic [3:0]              wb_op_q,    wb_op_d;
    logic [2:0]              wb_dest_q,  wb_dest_d;
    logic [DW-1:0]           wb_res_q,   wb_res_d;

    logic                    z_q, z_d, c_q, c_d;

    logic [DW-1:0]           alu_res;
    logic [NUM_DOMAINS-1:0]  lane_c;
    logic                    br_cond;

    for (genvar g = 0; g < NUM_DOMAINS; g++) begin : g_lane
        rns_lane_alu u_lane (
            .op_i     (ex_op_q),
            .a_i      (ex_op1_q[g*8 +: 8]),
            .b_i      (ex_op2_q[g*8 +: 8]),
            .imm_i    (ex_imm_q),
            .result_o (alu_res[g*8 +: 8]),
            .carry_o  (lane_c[g])
        );
    end

    // Flags are read by the branch in EX before they update, so a branch
    // right behind a flag-setting op sees the new value at the same edge.
    always_comb begin
        case (ex_op_q)
            OP_JMP:  br_cond = 1'b1;
            OP_BZ:   br_cond = z_q;
            OP_BNZ:  br_cond = ~z_q;
            OP_BC:   br_cond = c_q;
            default: br_cond = 1'b0;
        endcase
        branch_taken_EX = ex_valid_q & br_cond;
        nxt_prog_ctr_EX = ex_tgt_q;
    end

    // The instruction presented while a taken branch sits in EX is the
    // wrong-path slot; it is captured as a bubble. Bubbles load all-zero
    // fields so every derived output is 0 while nothing valid is in flight.
    always_comb begin
        ex_valid_d = id_valid & ~branch_taken_EX;
        ex_op_d    = '0;
        ex_dest_d  = '0;
        ex_op1_d   = '0;
        ex_op2_d   = '0;
        ex_imm_d   = '0;
        ex_tgt_d   = '0;
        if (ex_valid_d) begin
            ex_op_d   = id_opcode;
            ex_dest_d = id_dest;
            ex_op1_d  = id_op1_data;
            ex_op2_d  = id_op2_data;
            ex_imm_d  = id_imm;
            ex_tgt_d  = id_br_target;
        end

        wb_valid_d = ex_valid_q;
        wb_op_d    = ex_op_q;
        wb_dest_d  = ex_dest_q;
        wb_res_d   = alu_res;

        z_d = z_q;
        c_d = c_q;
        if (ex_valid_q && sets_flags(ex_op_q)) begin
            z_d = (alu_res == '0);
            c_d = |lane_c;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ex_valid_q <= 1'b0;
            ex_op_q    <= '0;
            ex_dest_q  <= '0;
            ex_op1_q   <= '0;
            ex_op2_q   <= '0;
            ex_imm_q   <= '0;
            ex_tgt_q   <= '0;
            wb_valid_q <= 1'b0;
            wb_op_q    <= '0;
            wb_dest_q  <= '0;
            wb_res_q   <= '0;
            z_q        <= 1'b0;
            c_q        <= 1'b0;
        end else begin
            ex_valid_q <= ex_valid_d;
            ex_op_q    <= ex_op_d;
            ex_dest_q  <= ex_dest_d;
            ex_op1_q   <= ex_op1_d;
            ex_op2_q   <= ex_op2_d;
            ex_imm_q   <= ex_imm_d;
            ex_tgt_q   <= ex_tgt_d;
            wb_valid_q <= wb_valid_d;
            wb_op_q    <= wb_op_d;
            wb_dest_q  <= wb_dest_d;
            wb_res_q   <= wb_res_d;
            z_q        <= z_d;
            c_q        <= c_d;
        end
    end

    always_comb begin
        dmem_addr            = ex_op1_q[7:0] + ex_imm_q;
        dmem_wr_en           = ex_valid_q & (ex_op_q == OP_ST);
        dmem_wr_data         = ex_op2_q;
        destination_reg_addr = ex_dest_q;
        reg_wr_en_reg        = ex_valid_q & writes_reg(ex_op_q);
        load_true_EX         = ex_valid_q & (ex_op_q == OP_LD);
        wr_en                = wb_valid_q & writes_reg(wb_op_q);
        wr_addr              = wb_dest_q;
        wr_data              = (wb_op_q == OP_LD) ? dmem_rd_data : wb_res_q;
    end

endmodule

// File: tb/tb_pl_ex_wb.sv
// tb_pl_ex_wb
//   Bench for pl_ex_wb with two RNS lanes. A spec-level model predicts every
//   output each cycle; directed sequences add literal expectations.
module tb_pl_ex_wb;
    import pl_ex_wb_pkg::*;

    localparam int unsigned ND  = 2;
    localparam int unsigned DW  = ND * 8;
    localparam int unsigned PCW = 10;

    logic           clk, reset;
    logic           id_valid;
    logic [3:0]     id_opcode;
    logic [2:0]     id_dest;
    logic [DW-1:0]  id_op1_data, id_op2_data;
    logic [7:0]     id_imm;
    logic [PCW-1:0] id_br_target;
    logic           branch_taken_EX;
    logic [PCW-1:0] nxt_prog_ctr_EX;
    logic [2:0]     destination_reg_addr;
    logic           reg_wr_en_reg, load_true_EX;
    logic [2:0]     wr_addr;
    logic [DW-1:0]  wr_data;
    logic           wr_en;

    pl_ex_wb_if #(.DW(DW)) mem_if ();

    pl_ex_wb #(.PROG_CTR_WID(PCW), .NUM_DOMAINS(ND)) dut (
        .clk                  (clk),
        .reset                (reset),
        .id_valid             (id_valid),
        .id_opcode            (id_opcode),
        .id_dest              (id_dest),
        .id_op1_data          (id_op1_data),
        .id_op2_data          (id_op2_data),
        .id_imm               (id_imm),
        .id_br_target         (id_br_target),
        .dmem_rd_data         (mem_if.rd_data),
        .dmem_addr            (mem_if.addr),
        .dmem_wr_en           (mem_if.wr_en),
        .dmem_wr_data         (mem_if.wr_data),
        .branch_taken_EX      (branch_taken_EX),
        .nxt_prog_ctr_EX      (nxt_prog_ctr_EX),
        .destination_reg_addr (destination_reg_addr),
        .reg_wr_en_reg        (reg_wr_en_reg),
        .load_true_EX         (load_true_EX),
        .wr_addr              (wr_addr),
        .wr_data              (wr_data),
        .wr_en                (wr_en)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous data memory (not reset).
    logic [DW-1:0] mem [256];
    always @(posedge clk) begin
        mem_if.rd_data <= mem[mem_if.addr];
        if (mem_if.wr_en) mem[mem_if.addr] <= mem_if.wr_data;
    end

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        else n_pass++;
    endtask

    // ---------------- behavioural model ----------------
    logic           m_ex_v, m_wb_v, m_z, m_c, m_tk;
    logic [3:0]     m_ex_op, m_wb_op;
    logic [2:0]     m_ex_dest, m_wb_dest;
    logic [DW-1:0]  m_ex_op1, m_ex_op2, m_wb_res, m_wb_ld;
    logic [7:0]     m_ex_imm, m_a;
    logic [PCW-1:0] m_ex_tgt;
    logic [DW:0]    m_r;
    logic [DW-1:0]  m_mem [256];

    // {carry, result} computed lane by lane with integer arithmetic.
    function automatic logic [DW:0] m_alu(input logic [3:0] op, input logic [DW-1:0] a,
                                          input logic [DW-1:0] b, input logic [7:0] imm);
        logic [DW-1:0] res;
        logic          c;
        int unsigned   x, y, r;
        res = '0;
        c   = 1'b0;
        for (int i = 0; i < ND; i++) begin
            x = int'(a[8*i +: 8]);
            y = int'(b[8*i +: 8]);
            case (op)
                OP_ADD: begin r = x + y; if (r > 255) c = 1'b1; end
                OP_SUB: begin r = x + 256 - y; if (x < y) c = 1'b1; end
                OP_AND: r = x & y;
                OP_OR:  r = x | y;
                OP_XOR: r = x ^ y;
                OP_MOV: r = x;
                OP_LDI: r = int'(imm);
                default: r = 0;
            endcase
            res[8*i +: 8] = 8'(r % 256);
        end
        return {c, res};
    endfunction

    function automatic logic m_taken(input logic v, input logic [3:0] op, input logic z, input logic c);
        return v && ((op == OP_JMP) || (op == OP_BZ && z) || (op == OP_BNZ && !z) || (op == OP_BC && c));
    endfunction

    function automatic logic [7:0] m_addr(input logic [DW-1:0] op1, input logic [7:0] imm);
        return 8'((int'(op1[7:0]) + int'(imm)) % 256);
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_ex_v = 0; m_ex_op = '0; m_ex_dest = '0; m_ex_op1 = '0; m_ex_op2 = '0;
            m_ex_imm = '0; m_ex_tgt = '0;
            m_wb_v = 0; m_wb_op = '0; m_wb_dest = '0; m_wb_res = '0; m_wb_ld = '0;
            m_z = 0; m_c = 0;
        end else begin
            m_r  = m_alu(m_ex_op, m_ex_op1, m_ex_op2, m_ex_imm);
            m_tk = m_taken(m_ex_v, m_ex_op, m_z, m_c);
            m_a  = m_addr(m_ex_op1, m_ex_imm);
            m_wb_v = m_ex_v; m_wb_op = m_ex_op; m_wb_dest = m_ex_dest;
            m_wb_res = m_r[DW-1:0];
            m_wb_ld  = m_mem[m_a];
            if (m_ex_v && m_ex_op == OP_ST) m_mem[m_a] = m_ex_op2;
            if (m_ex_v && m_ex_op >= OP_ADD && m_ex_op <= OP_LDI) begin
                m_z = (m_r[DW-1:0] == '0);
                m_c = m_r[DW];
            end
            if (id_valid && !m_tk) begin
                m_ex_v = 1; m_ex_op = id_opcode; m_ex_dest = id_dest; m_ex_op1 = id_op1_data;
                m_ex_op2 = id_op2_data; m_ex_imm = id_imm; m_ex_tgt = id_br_target;
            end else begin
                m_ex_v = 0; m_ex_op = '0; m_ex_dest = '0; m_ex_op1 = '0; m_ex_op2 = '0;
                m_ex_imm = '0; m_ex_tgt = '0;
            end
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        chk("branch_taken", 32'(branch_taken_EX), 32'(m_taken(m_ex_v, m_ex_op, m_z, m_c)));
        chk("nxt_pc",       32'(nxt_prog_ctr_EX), 32'(m_ex_tgt));
        chk("dmem_addr",    32'(mem_if.addr),     32'(m_addr(m_ex_op1, m_ex_imm)));
        chk("dmem_wr_en",   32'(mem_if.wr_en),    32'(m_ex_v && m_ex_op == OP_ST));
        chk("dmem_wr_data", 32'(mem_if.wr_data),  32'(m_ex_op2));
        chk("fwd_dest",     32'(destination_reg_addr), 32'(m_ex_dest));
        chk("fwd_wr_en",    32'(reg_wr_en_reg),   32'(m_ex_v && m_ex_op >= OP_ADD && m_ex_op <= OP_LD));
        chk("fwd_load",     32'(load_true_EX),    32'(m_ex_v && m_ex_op == OP_LD));
        chk("wr_en",        32'(wr_en),           32'(m_wb_v && m_wb_op >= OP_ADD && m_wb_op <= OP_LD));
        chk("wr_addr",      32'(wr_addr),         32'(m_wb_dest));
        chk("wr_data",      32'(wr_data),         32'((m_wb_op == OP_LD) ? m_wb_ld : m_wb_res));
    end

    // ---------------- directed stimulus ----------------
    task automatic issue(input logic v, input logic [3:0] op, input logic [2:0] d,
                         input logic [DW-1:0] a, input logic [DW-1:0] b,
                         input logic [7:0] im, input logic [PCW-1:0] t);
        id_valid = v; id_opcode = op; id_dest = d; id_op1_data = a;
        id_op2_data = b; id_imm = im; id_br_target = t;
        @(posedge clk);
        #1;
    endtask

    task automatic bubble();
        issue(1'b0, OP_NOP, 3'd0, '0, '0, 8'h00, '0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 256; i++) begin
            mem[i]   = {8'hA5, 8'(i)};
            m_mem[i] = {8'hA5, 8'(i)};
        end
        reset = 1'b1;
        id_valid = 0; id_opcode = '0; id_dest = '0; id_op1_data = '0;
        id_op2_data = '0; id_imm = '0; id_br_target = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_wr_en", 32'(wr_en), 32'd0);
        chk("reset_branch", 32'(branch_taken_EX), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk); #1;

        // ADD with lane-0 carry, then BC observes C=1; successor squashed.
        issue(1, OP_ADD, 3'd3, 16'h00F0, 16'h0020, 8'h00, '0);
        chk("add_fwd_wr_en", 32'(reg_wr_en_reg), 32'd1);
        chk("add_fwd_dest", 32'(destination_reg_addr), 32'd3);
        issue(1, OP_BC, 3'd0, '0, '0, 8'h00, 10'h155);
        chk("add_wr_en", 32'(wr_en), 32'd1);
        chk("add_wr_addr", 32'(wr_addr), 32'd3);
        chk("add_wr_data", 32'(wr_data), 32'h0010);
        chk("bc_taken", 32'(branch_taken_EX), 32'd1);
        chk("bc_target", 32'(nxt_prog_ctr_EX), 32'h155);
        issue(1, OP_ADD, 3'd2, 16'h0001, 16'h0001, 8'h00, '0);
        chk("squash_fwd_wr_en", 32'(reg_wr_en_reg), 32'd0);
        bubble();
        chk("squash_wr_en", 32'(wr_en), 32'd0);

        // SUB to zero, BZ right behind it, squashed ADD.
        issue(1, OP_SUB, 3'd1, 16'h0055, 16'h0055, 8'h00, '0);
        issue(1, OP_BZ, 3'd0, '0, '0, 8'h00, 10'h1A0);
        chk("bz_taken", 32'(branch_taken_EX), 32'd1);
        chk("bz_target", 32'(nxt_prog_ctr_EX), 32'h1A0);
        chk("sub_wr_data", 32'(wr_data), 32'h0000);
        issue(1, OP_ADD, 3'd2, 16'h0003, 16'h0004, 8'h00, '0);
        bubble();
        chk("bz_squash_wr_en", 32'(wr_en), 32'd0);

        // Store then load the same location.
        issue(1, OP_ST, 3'd0, 16'h0010, 16'h0077, 8'h05, '0);
        chk("st_wr_en", 32'(mem_if.wr_en), 32'd1);
        chk("st_addr", 32'(mem_if.addr), 32'h15);
        chk("st_data", 32'(mem_if.wr_data), 32'h0077);
        issue(1, OP_LD, 3'd4, 16'h0015, '0, 8'h00, '0);
        chk("ld_load_true", 32'(load_true_EX), 32'd1);
        chk("st_no_wb", 32'(wr_en), 32'd0);
        bubble();
        chk("ld_wr_en", 32'(wr_en), 32'd1);
        chk("ld_wr_addr", 32'(wr_addr), 32'd4);
        chk("ld_wr_data", 32'(wr_data), 32'h0077);

        // Bubbles hold the flags: Z=1, C=0 from the SUB.
        for (int i = 0; i < 2; i++) begin
            bubble();
            chk("bubble_wr_en", 32'(wr_en), 32'd0);
            chk("bubble_st", 32'(mem_if.wr_en), 32'd0);
        end
        issue(1, OP_BC, 3'd0, '0, '0, 8'h00, 10'h0AA);
        chk("bc_not_taken", 32'(branch_taken_EX), 32'd0);
        issue(1, OP_BZ, 3'd0, '0, '0, 8'h00, 10'h2B3);
        chk("bz_held_taken", 32'(branch_taken_EX), 32'd1);
        bubble();

        // LDI replicated, ADD wraps every lane to 0: Z=1, C=1.
        issue(1, OP_LDI, 3'd5, '0, '0, 8'h80, '0);
        issue(1, OP_ADD, 3'd6, 16'h8080, 16'h8080, 8'h00, '0);
        chk("ldi_wr_data", 32'(wr_data), 32'h8080);
        issue(1, OP_BZ, 3'd0, '0, '0, 8'h00, 10'h011);
        chk("wrap_wr_data", 32'(wr_data), 32'h0000);
        chk("wrap_bz_taken", 32'(branch_taken_EX), 32'd1);
        issue(1, OP_JMP, 3'd0, '0, '0, 8'h00, 10'h3FF);
        chk("squashed_jmp", 32'(branch_taken_EX), 32'd0);
        issue(1, OP_BC, 3'd0, '0, '0, 8'h00, 10'h222);
        chk("wrap_bc_taken", 32'(branch_taken_EX), 32'd1);
        chk("wrap_bc_target", 32'(nxt_prog_ctr_EX), 32'h222);
        bubble();

        // Back-to-back writes to r7 retire in order.
        issue(1, OP_ADD, 3'd7, 16'h0101, 16'h0202, 8'h00, '0);
        issue(1, OP_MOV, 3'd7, 16'h0ABC, '0, 8'h00, '0);
        issue(1, OP_XOR, 3'd2, 16'h00FF, 16'h0F0F, 8'h00, '0);
        chk("r7_first", 32'(wr_data), 32'h0ABC);
        bubble();
        chk("xor_wr_data", 32'(wr_data), 32'h0FF0);
        bubble();

        // Reset with ST in EX and ADD in WB.
        issue(1, OP_ADD, 3'd1, 16'h0001, 16'h0002, 8'h00, '0);
        issue(1, OP_ST, 3'd0, 16'h0020, 16'h1234, 8'h00, '0);
        chk("pre_rst_st", 32'(mem_if.wr_en), 32'd1);
        chk("pre_rst_wb", 32'(wr_en), 32'd1);
        #1 reset = 1'b1;
        id_valid = 1'b0;
        #1;
        chk("rst_st_drop", 32'(mem_if.wr_en), 32'd0);
        chk("rst_wb_drop", 32'(wr_en), 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk); #1;
        bubble();
        chk("rst_no_store", 32'(mem[8'h20]), 32'hA520);
        issue(1, OP_BNZ, 3'd0, '0, '0, 8'h00, 10'h0C3);
        chk("post_rst_bnz", 32'(branch_taken_EX), 32'd1);
        bubble();
        bubble();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
